// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores on the req/gnt/rvalid data-memory
// port, stalls upstream while an access is in flight, and owns MEM/WB.
module mem_stage #(
  parameter int D_SIZE        = 32,
  parameter int ADDR_LINE_REG = 5,
  parameter int STALL_CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ex_valid_f_ex,
  input  logic                     mem_read_f_ex,
  input  logic                     mem_write_f_ex,
  input  logic                     mem_to_reg_f_ex,
  input  logic                     reg_write_f_ex,
  input  logic [D_SIZE-1:0]        alu_out_f_ex,
  input  logic [D_SIZE-1:0]        store_data_f_ex,
  input  logic [ADDR_LINE_REG-1:0] rd_addr_f_ex,
  output logic                     stall_f_mem,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [D_SIZE-1:0]        dmem_addr,
  output logic [D_SIZE-1:0]        dmem_wdata,
  input  logic                     dmem_gnt,
  input  logic                     dmem_rvalid,
  input  logic [D_SIZE-1:0]        dmem_rdata,
  output logic                     mem_to_reg_f_mem,
  output logic                     reg_write_f_mem_2_wb,
  output logic [D_SIZE-1:0]        alu_out_f_mem_2_wb,
  output logic [ADDR_LINE_REG-1:0] alu_add_f_mem_2_wb,
  output logic [STALL_CNT_W-1:0]   stall_cycles
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic memop;
  logic capture;
  logic wb_alu;
  logic wb_load;

  logic [D_SIZE-1:0]        addr_p0;
  logic [D_SIZE-1:0]        wdata_p0;
  logic                     we_p0;
  logic [ADDR_LINE_REG-1:0] rd_p0;
  logic                     reg_write_p0;
  logic                     mem_to_reg_p0;
  // Load completion always selects memory data, so the captured flag has no consumer.
  logic                     unused_mem_to_reg;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + STALL_CNT_W'(1);
  endfunction

  assign memop   = ex_valid_f_ex & (mem_read_f_ex | mem_write_f_ex);
  assign capture = (state == IDLE) & memop;
  assign wb_alu  = (state == IDLE) & ex_valid_f_ex & ~memop;
  assign wb_load = (state == WAIT_RSP) & dmem_rvalid;

  assign dmem_req   = (state == REQ);
  assign dmem_we    = we_p0;
  assign dmem_addr  = addr_p0;
  assign dmem_wdata = wdata_p0;

  assign unused_mem_to_reg = mem_to_reg_p0;

  // Stall releases in the completing cycle so EX advances on that same edge.
  always_comb begin
    state_nxt   = state;
    stall_f_mem = 1'b0;
    case (state)
      IDLE: begin
        if (memop) begin
          stall_f_mem = 1'b1;
          state_nxt   = REQ;
        end
      end
      REQ: begin
        if (!dmem_gnt) begin
          stall_f_mem = 1'b1;
        end else if (we_p0) begin
          state_nxt = IDLE;
        end else begin
          stall_f_mem = 1'b1;
          state_nxt   = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (dmem_rvalid) state_nxt = IDLE;
        else             stall_f_mem = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Request capture: EX fields frozen for the whole access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_p0       <= '0;
      wdata_p0      <= '0;
      we_p0         <= 1'b0;
      rd_p0         <= '0;
      reg_write_p0  <= 1'b0;
      mem_to_reg_p0 <= 1'b0;
    end else if (capture) begin
      addr_p0       <= alu_out_f_ex;
      wdata_p0      <= store_data_f_ex;
      we_p0         <= mem_write_f_ex;
      rd_p0         <= rd_addr_f_ex;
      reg_write_p0  <= reg_write_f_ex;
      mem_to_reg_p0 <= mem_to_reg_f_ex;
    end
  end

  // MEM/WB boundary: bubbles clear only the control bits, data holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_f_mem_2_wb <= 1'b0;
      mem_to_reg_f_mem     <= 1'b0;
      alu_out_f_mem_2_wb   <= '0;
      alu_add_f_mem_2_wb   <= '0;
    end else begin
      reg_write_f_mem_2_wb <= 1'b0;
      mem_to_reg_f_mem     <= 1'b0;
      if (wb_alu) begin
        reg_write_f_mem_2_wb <= reg_write_f_ex;
        alu_out_f_mem_2_wb   <= alu_out_f_ex;
        alu_add_f_mem_2_wb   <= rd_addr_f_ex;
      end else if (wb_load) begin
        reg_write_f_mem_2_wb <= reg_write_p0;
        mem_to_reg_f_mem     <= 1'b1;
        alu_out_f_mem_2_wb   <= dmem_rdata;
        alu_add_f_mem_2_wb   <= rd_p0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           stall_cycles <= '0;
    else if (stall_f_mem) stall_cycles <= sat_inc(stall_cycles);
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage pipeline, between EX and write-back.
- Issues loads and stores to the data-memory port using a req/gnt/rvalid handshake, and stalls upstream while a request is outstanding.
- Owns the MEM/WB pipeline register. It drives the write-back stage with the write-back data, destination register address and mem-to-reg flag.

Parameters:
D_SIZE, 32, datapath and data-memory word width
ADDR_LINE_REG, 5, register-file address width
STALL_CNT_W, 16, width of the stall-cycle performance counter

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
ex_valid_f_ex  in  1  EX presents a valid instruction
mem_read_f_ex  in  1  instruction is a load
mem_write_f_ex  in  1  instruction is a store
mem_to_reg_f_ex  in  1  write-back source is memory
reg_write_f_ex  in  1  instruction writes the register file
alu_out_f_ex  in  D_SIZE  ALU result, or effective address for loads and stores
store_data_f_ex  in  D_SIZE  store data
rd_addr_f_ex  in  ADDR_LINE_REG  destination register
stall_f_mem  out  1  EX/ID/IF must hold their state
dmem_req  out  1  data-memory request
dmem_we  out  1  1 = write, 0 = read
dmem_addr  out  D_SIZE  request address
dmem_wdata  out  D_SIZE  write data
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  read data valid
dmem_rdata  in  D_SIZE  read data
mem_to_reg_f_mem  out  1  registered mem-to-reg flag to write-back
reg_write_f_mem_2_wb  out  1  registered register-write enable to write-back
alu_out_f_mem_2_wb  out  D_SIZE  registered write-back data (load data or ALU result)
alu_add_f_mem_2_wb  out  ADDR_LINE_REG  registered destination address
stall_cycles  out  STALL_CNT_W  saturating count of cycles with stall_f_mem=1

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state goes to IDLE.
  - All registered outputs, latched request fields and stall_cycles clear to 0.
  - dmem_req drops to 0 immediately.
  - A reset mid-transaction abandons the access. Any late gnt/rvalid arriving after reset is ignored.
- Definitions: memop = ex_valid_f_ex & (mem_read_f_ex | mem_write_f_ex). If mem_read_f_ex and mem_write_f_ex are both set, the instruction is treated as a store.
- FSM states: IDLE, REQ, WAIT_RSP.
- IDLE with ex_valid=1 and no memop:
  - Next edge loads MEM/WB: alu_out_f_mem_2_wb=alu_out_f_ex, alu_add=rd_addr_f_ex, reg_write=reg_write_f_ex, mem_to_reg=0.
  - Latency 1 cycle, no stall.
- IDLE with ex_valid=0: next edge loads a bubble (reg_write=0, mem_to_reg=0). Data and address fields hold their previous values.
- IDLE with memop:
  - stall_f_mem=1 combinationally.
  - Next edge latches addr, wdata, we, rd, reg_write and mem_to_reg; loads a bubble into MEM/WB; moves to REQ.
- REQ:
  - dmem_req=1, with dmem_addr, dmem_wdata and dmem_we taken from the latched values.
  - Outputs hold stable until dmem_gnt.
  - Store with gnt: stall_f_mem=0 that cycle, next state IDLE, MEM/WB bubble.
  - Load with gnt: next state WAIT_RSP, stall stays 1.
  - Without gnt: remain in REQ.
- WAIT_RSP:
  - dmem_req=0.
  - On dmem_rvalid: stall_f_mem=0 that cycle. Next edge loads MEM/WB with alu_out_f_mem_2_wb=dmem_rdata, mem_to_reg=1, reg_write and rd from the latched values, then returns to IDLE.
  - Without rvalid: stay in WAIT_RSP, stall=1.
- Protocol: rvalid never arrives in the same cycle as gnt. An rvalid seen in IDLE or REQ is ignored.
- Stall handshake:
  - stall deasserts exactly in the completing cycle, so EX advances on that edge.
  - Outside IDLE, EX inputs are ignored.
  - Minimum costs: load = 3 cycles (2 stalled), store = 2 cycles (1 stalled).
- Idle data-memory port: dmem_addr, dmem_wdata and dmem_we hold their last latched values while dmem_req=0.
- stall_cycles: increments on every cycle with stall_f_mem=1 and saturates at 2^STALL_CNT_W-1 (no wrap).

Test Plan:
- ALU op after reset: ex_valid=1, reg_write=1, alu_out=0x0000_00A5, rd=7 -> next cycle alu_out_f_mem_2_wb=0xA5, alu_add=7, reg_write=1, mem_to_reg=0; stall never asserted.
- Load, immediate gnt, rvalid one cycle later with rdata=0xDEAD_BEEF, rd=3 -> dmem_req=1 for 1 cycle with addr=alu_out; stall high for 2 cycles; then alu_out_f_mem_2_wb=0xDEADBEEF, mem_to_reg=1, alu_add=3; stall_cycles=2.
- Store to 0x100 with data 0x1234, gnt delayed 3 cycles -> dmem_req, addr, wdata and we=1 stable for 4 cycles; stall deasserts in the gnt cycle; MEM/WB reg_write=0 throughout; stall_cycles=4.
- Back-to-back load then ALU op -> EX holds the ALU op during the stall; the ALU op is accepted only after the rvalid cycle; the load result is presented to write-back one cycle before the ALU result.
- rst_n pulsed low while in WAIT_RSP, with a stray rvalid after release -> all outputs 0, state IDLE, stray rvalid ignored, next ALU op completes normally.
- STALL_CNT_W=4, one load with 20 cycles of gnt delay -> stall_cycles saturates at 15.
